// File: rtl/mor1kx_tick_timer_spr_if.sv
// SPR bus between the CPU SPR initiator and one SPR-group responder.
//   access : request, held by the initiator until ack
//   we     : 1 = mtspr, 0 = mfspr; stable while access is high
//   addr   : {group[4:0], index[10:0]}
//   wdat   : write data
//   ack    : one-cycle acknowledge from the responder
//   rdat   : read data, valid only with ack, 0 otherwise
interface mor1kx_tick_timer_spr_if;
  logic        access;
  logic        we;
  logic [15:0] addr;
  logic [31:0] wdat;
  logic        ack;
  logic [31:0] rdat;

  modport master (output access, we, addr, wdat, input  ack, rdat);
  modport slave  (input  access, we, addr, wdat, output ack, rdat);
endinterface

// File: rtl/mor1kx_tick_timer_spr.sv
// Tick timer SPR responder (group SPR_GROUP): TTMR at index 0, TTCR at index 1.
// Serves mfspr/mtspr with a one-cycle-latency ack, runs the 32-bit tick
// counter and raises the timer interrupt (TTMR.IP).
// Ports:
//   clk, rst_n  : core clock, asynchronous active-low reset
//   spr         : SPR bus, slave side (access/we/addr/wdat in, ack/rdat out)
//   du_stall_i  : debug-unit stall, freezes the counter when FREEZE_ON_DU
//   tt_irq_o    : timer interrupt, equal to TTMR.IP
// TTMR layout: [31:30] mode, [29] IE, [28] IP, [27:0] TP.
module mor1kx_tick_timer_spr #(
  parameter logic [4:0]  SPR_GROUP    = 5'd10,
  parameter logic [31:0] TTCR_RESET   = 32'd0,
  parameter bit          FREEZE_ON_DU = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mor1kx_tick_timer_spr_if.slave   spr,
  input  logic                     du_stall_i,
  output logic                     tt_irq_o
);

  localparam logic [1:0] M_DIS     = 2'b00;
  localparam logic [1:0] M_RESTART = 2'b01;
  localparam logic [1:0] M_STOP    = 2'b10;
  localparam logic [1:0] M_CONT    = 2'b11;

  logic [31:0] ttmr_q, ttmr_d;
  logic [31:0] ttcr_q, ttcr_d;
  logic        ack_q,  ack_d;
  logic [31:0] rdat_q, rdat_d;

  logic        sel;
  logic [10:0] idx;
  logic        wr_ttmr, wr_ttcr;
  logic [1:0]  mode;
  logic        match;
  logic        cnt_en;

  always_comb begin
    // ack_q blocks re-sampling the still-held request in the ack cycle,
    // which gives the one-access-per-two-cycles rate.
    sel     = spr.access && (spr.addr[15:11] == SPR_GROUP) && !ack_q;
    idx     = spr.addr[10:0];
    wr_ttmr = sel && spr.we && (idx == 11'd0);
    wr_ttcr = sel && spr.we && (idx == 11'd1);

    mode    = ttmr_q[31:30];
    // Match and IE always use the TTMR as it stands; a TTMR write this
    // cycle only affects matching from the next cycle.
    match   = (mode != M_DIS) && (ttcr_q[27:0] == ttmr_q[27:0]);
    cnt_en  = (mode != M_DIS) && !(FREEZE_ON_DU && du_stall_i);

    ack_d   = sel;
    rdat_d  = '0;
    if (sel && !spr.we) begin
      case (idx)
        11'd0:   rdat_d = ttmr_q;
        11'd1:   rdat_d = ttcr_q;
        default: rdat_d = '0;
      endcase
    end

    // A software TTCR write overrides counting for that cycle.
    ttcr_d = ttcr_q;
    if (wr_ttcr) begin
      ttcr_d = spr.wdat;
    end else if (cnt_en) begin
      case (mode)
        M_RESTART: ttcr_d = match ? 32'd0 : ttcr_q + 32'd1;
        M_STOP:    ttcr_d = match ? ttcr_q : ttcr_q + 32'd1;
        M_CONT:    ttcr_d = ttcr_q + 32'd1;
        default:   ttcr_d = ttcr_q;
      endcase
    end

    // IP is only ever set by hardware; software can only clear it by
    // writing 0. The hardware set is applied last so it wins.
    ttmr_d = ttmr_q;
    if (wr_ttmr) begin
      ttmr_d[31:29] = spr.wdat[31:29];
      ttmr_d[27:0]  = spr.wdat[27:0];
      if (!spr.wdat[28]) ttmr_d[28] = 1'b0;
    end
    if (match && ttmr_q[29]) ttmr_d[28] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ttmr_q <= '0;
      ttcr_q <= TTCR_RESET;
      ack_q  <= 1'b0;
      rdat_q <= '0;
    end else begin
      ttmr_q <= ttmr_d;
      ttcr_q <= ttcr_d;
      ack_q  <= ack_d;
      rdat_q <= rdat_d;
    end
  end

  assign spr.ack  = ack_q;
  assign spr.rdat = rdat_q;
  assign tt_irq_o = ttmr_q[28];

endmodule

// File: tb/tb_mor1kx_tick_timer_spr.sv
module tb_mor1kx_tick_timer_spr;
  localparam logic [15:0] A_TTMR  = 16'h5000;
  localparam logic [15:0] A_TTCR  = 16'h5001;
  localparam logic [15:0] A_IDX2  = 16'h5002;
  localparam logic [15:0] A_OTHER = 16'h4800;

  typedef struct packed {
    logic [31:0] dat;
    logic        irq;
    logic [7:0]  id;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic du_stall = 1'b0;
  logic tt_irq;
  int   total = 0;
  int   bad = 0;
  exp_t sbq[$];

  mor1kx_tick_timer_spr_if bus ();

  mor1kx_tick_timer_spr #(
    .SPR_GROUP(5'd10), .TTCR_RESET(32'd0), .FREEZE_ON_DU(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spr(bus),
    .du_stall_i(du_stall), .tt_irq_o(tt_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive one access at a negedge; sampled at the next posedge; one idle
  // cycle afterwards so consecutive calls sample two edges apart.
  task automatic xfer(input logic we, input logic [15:0] addr, input logic [31:0] wdat,
                      input logic exp_ack, input logic [31:0] exp_dat, input logic exp_irq,
                      input logic [7:0] id);
    if (exp_ack) sbq.push_back('{dat: exp_dat, irq: exp_irq, id: id});
    bus.access = 1'b1;
    bus.we     = we;
    bus.addr   = addr;
    bus.wdat   = wdat;
    @(posedge clk);
    @(negedge clk);
    bus.access = 1'b0;
    bus.we     = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] d, input logic irq, input logic [7:0] id);
    xfer(1'b0, a, 32'h0, 1'b1, d, irq, id);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic irq, input logic [7:0] id);
    xfer(1'b1, a, d, 1'b1, 32'h0, irq, id);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every ack pops one expectation; no ack means data must be 0.
  always begin
    @(posedge clk);
    #1;
    if (bus.ack === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_ack: got ack with data %h, want no ack", bus.rdat);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk($sformatf("rdat_id%0d", e.id), bus.rdat, e.dat);
        chk($sformatf("irq_id%0d", e.id), {31'h0, tt_irq}, {31'h0, e.irq});
      end
    end else begin
      chk("rdat_idle_zero", bus.rdat, 32'h0);
    end
  end

  initial begin
    bus.access = 1'b0;
    bus.we     = 1'b0;
    bus.addr   = '0;
    bus.wdat   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_ack", {31'h0, bus.ack}, 32'h0);
    chk("reset_rdat", bus.rdat, 32'h0);
    chk("reset_irq", {31'h0, tt_irq}, 32'h0);

    // Reset values, foreign group, unknown index
    rd(A_TTMR, 32'h0, 1'b0, 1);
    rd(A_TTCR, 32'h0, 1'b0, 2);
    xfer(1'b0, A_OTHER, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    xfer(1'b1, A_OTHER, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 0);
    rd(A_IDX2, 32'h0, 1'b0, 3);
    wr(A_IDX2, 32'hFFFF_FFFF, 1'b0, 4);
    rd(A_TTMR, 32'h0, 1'b0, 5);
    rd(A_TTCR, 32'h0, 1'b0, 6);

    // Restart mode, TP=5, IE: period 6; write edge S0, TTCR after S0+k = k mod 6
    wr(A_TTMR, 32'h6000_0005, 1'b0, 10);   // S0
    rd(A_TTCR, 32'd1, 1'b0, 11);           // S0+2
    rd(A_TTCR, 32'd3, 1'b0, 12);           // S0+4
    rd(A_TTCR, 32'd5, 1'b1, 13);           // S0+6: IP set here
    rd(A_TTCR, 32'd1, 1'b1, 14);           // S0+8: wrapped to 0 then 1
    rd(A_TTMR, 32'h7000_0005, 1'b1, 15);   // S0+10

    // IP clear colliding with a match: hardware set wins
    wr(A_TTMR, 32'h6000_0005, 1'b1, 20);   // S0+12, TTCR==5
    // IP clear with no match
    wr(A_TTMR, 32'h6000_0005, 1'b0, 21);   // S0+14, TTCR==1
    rd(A_TTMR, 32'h6000_0005, 1'b0, 22);   // S0+16

    // Stop-on-match TP=3, IE=0. Old restart TTMR still matches at S0+18.
    wr(A_TTMR, 32'h8000_0003, 1'b1, 30);   // S0+18, TTCR->0, IP set by old IE
    wr(A_TTMR, 32'h8000_0003, 1'b0, 31);   // S0+20, clears IP
    idle(20);
    rd(A_TTCR, 32'd3, 1'b0, 32);           // held at 3
    wr(A_TTCR, 32'd0, 1'b0, 33);
    rd(A_TTCR, 32'd1, 1'b0, 34);
    rd(A_TTCR, 32'd3, 1'b0, 35);
    rd(A_TTCR, 32'd3, 1'b0, 36);

    // Continue mode, TP=0, IE; wrap through 0xFFFFFFFF. Write edge B.
    wr(A_TTMR, 32'hE000_0000, 1'b0, 40);   // B, TTCR 3
    wr(A_TTCR, 32'hFFFF_FFFE, 1'b0, 41);   // B+2
    rd(A_TTCR, 32'hFFFF_FFFF, 1'b0, 42);   // B+4, TTCR->0 here
    rd(A_TTCR, 32'd1, 1'b1, 43);           // B+6
    rd(A_TTCR, 32'd3, 1'b1, 44);           // B+8

    // Debug stall freezes counter for edges B+10..B+19 (value 5)
    du_stall = 1'b1;
    idle(8);
    rd(A_TTCR, 32'd5, 1'b1, 50);           // B+18
    du_stall = 1'b0;
    rd(A_TTCR, 32'd5, 1'b1, 51);           // B+20, last frozen value
    rd(A_TTCR, 32'd7, 1'b1, 52);           // B+22
    wr(A_TTCR, 32'h1234_5678, 1'b1, 53);   // B+24, no +1 on the write edge
    rd(A_TTCR, 32'h1234_5679, 1'b1, 54);   // B+26

    // IP=1 on write keeps IP; disable mode freezes counter
    wr(A_TTMR, 32'hF000_0000, 1'b1, 60);   // B+28
    wr(A_TTMR, 32'h0000_0000, 1'b0, 61);   // B+30, TTCR ends at ...7E
    rd(A_TTMR, 32'h0000_0000, 1'b0, 62);
    rd(A_TTCR, 32'h1234_567E, 1'b0, 63);
    rd(A_TTCR, 32'h1234_567E, 1'b0, 64);

    // Reset in the middle of a write: no ack, no write
    bus.access = 1'b1;
    bus.we     = 1'b1;
    bus.addr   = A_TTCR;
    bus.wdat   = 32'hDEAD_BEEF;
    rst_n      = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_ack", {31'h0, bus.ack}, 32'h0);
    @(negedge clk);
    bus.access = 1'b0;
    bus.we     = 1'b0;
    rst_n      = 1'b1;
    @(negedge clk);
    rd(A_TTCR, 32'h0, 1'b0, 70);
    rd(A_TTMR, 32'h0, 1'b0, 71);

    idle(4);
    chk("sb_drained", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
